// File: rtl/plic_gateway_target.sv
// PLIC per-source gateways and single-target claim/complete logic.
// Gateways feed the arbiter; its delayed max-priority id is filtered, thresholded and claimed here.
module plic_gateway_target #(
    parameter int PLIC_NUM_SOURCES = 32,
    parameter int ARB_LATENCY      = 6,
    parameter int ID_W             = $clog2(PLIC_NUM_SOURCES)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PLIC_NUM_SOURCES-1:0]         irq_src_in,
    input  logic [PLIC_NUM_SOURCES-1:0]         irq_edge_in,
    input  logic [PLIC_NUM_SOURCES-1:0]         enable_in,
    input  logic [PLIC_NUM_SOURCES-1:0][7:0]    pri_in,
    input  logic [7:0]                          threshold_in,
    output logic [PLIC_NUM_SOURCES-1:0]         arb_valid_out,
    input  logic [ID_W-1:0]                     arb_id_in,
    input  logic                                arb_valid_in,
    output logic                                ext_irq_out,
    input  logic                                claim_req_in,
    output logic                                claim_rsp_valid_out,
    output logic [ID_W-1:0]                     claim_id_out,
    input  logic                                complete_req_in,
    input  logic [ID_W-1:0]                     complete_id_in,
    output logic [PLIC_NUM_SOURCES-1:0]         pending_out
);
    localparam int N  = PLIC_NUM_SOURCES;
    localparam int BW = $clog2(ARB_LATENCY + 1);

    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    in_service_q, in_service_d;
    logic [N-1:0]    edge_held_q, edge_held_d;
    logic [N-1:0]    irq_src_q;
    logic [N-1:0]    edge_mode_q;
    logic            cand_vld_q, cand_vld_d;
    logic [ID_W-1:0] cand_id_q, cand_id_d;
    logic [BW-1:0]   blank_q, blank_d;
    logic            ext_irq_q;
    logic            claim_rsp_q;
    logic [ID_W-1:0] claim_id_q, claim_id_d;

    logic            claim_fire;
    logic            complete_fire;
    logic [N-1:0]    claim_hit;
    logic [N-1:0]    complete_hit;

    assign claim_fire    = claim_req_in & cand_vld_q;
    assign complete_fire = |complete_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_gw
            if (gi == 0) begin : g_src0
                logic unused_src0;
                assign unused_src0     = ^{irq_src_q[0], edge_mode_q[0], in_service_q[0],
                                           edge_held_q[0], irq_src_in[0], irq_edge_in[0]};
                assign claim_hit[0]    = 1'b0;
                assign complete_hit[0] = 1'b0;
                assign pending_d[0]    = 1'b0;
                assign in_service_d[0] = 1'b0;
                assign edge_held_d[0]  = 1'b0;
            end else begin : g_src
                logic rise;
                logic blocked;
                logic trig;
                assign claim_hit[gi]    = claim_fire & (cand_id_q == ID_W'(gi));
                assign complete_hit[gi] = complete_req_in & (complete_id_in == ID_W'(gi))
                                          & in_service_q[gi];
                assign rise    = irq_src_in[gi] & ~irq_src_q[gi];
                assign blocked = in_service_q[gi] | claim_hit[gi];
                assign trig    = irq_edge_in[gi] ? rise : irq_src_in[gi];

                assign pending_d[gi]    = claim_hit[gi] ? 1'b0 :
                                          (pending_q[gi] | (trig & ~blocked)
                                           | (complete_hit[gi] & edge_held_q[gi]));
                assign in_service_d[gi] = claim_hit[gi] | (in_service_q[gi] & ~complete_hit[gi]);
                // A held edge is released by completion; a new edge while busy is held (one deep).
                assign edge_held_d[gi]  = (irq_edge_in[gi] != edge_mode_q[gi]) ? 1'b0 :
                                          ((edge_held_q[gi] & ~complete_hit[gi])
                                           | (irq_edge_in[gi] & rise & blocked));
            end
        end
    endgenerate

    always_comb begin
        cand_id_d  = cand_id_q;
        cand_vld_d = 1'b0;
        blank_d    = blank_q;
        claim_id_d = claim_id_q;

        // Re-checking pending drops stale arbiter results for already-claimed sources.
        if (blank_q == '0) begin
            cand_id_d = arb_id_in;
            if (!claim_fire && !complete_fire) begin
                cand_vld_d = arb_valid_in & pending_q[arb_id_in] & enable_in[arb_id_in]
                             & (pri_in[arb_id_in] > threshold_in) & (arb_id_in != '0);
            end
        end

        if (claim_fire || complete_fire) begin
            blank_d = BW'(ARB_LATENCY);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end

        if (claim_req_in) begin
            claim_id_d = cand_vld_q ? cand_id_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            in_service_q <= '0;
            edge_held_q  <= '0;
            irq_src_q    <= '0;
            edge_mode_q  <= '0;
            cand_vld_q   <= 1'b0;
            cand_id_q    <= '0;
            blank_q      <= '0;
            ext_irq_q    <= 1'b0;
            claim_rsp_q  <= 1'b0;
            claim_id_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            edge_held_q  <= edge_held_d;
            irq_src_q    <= irq_src_in;
            edge_mode_q  <= irq_edge_in;
            cand_vld_q   <= cand_vld_d;
            cand_id_q    <= cand_id_d;
            blank_q      <= blank_d;
            ext_irq_q    <= cand_vld_d;
            claim_rsp_q  <= claim_req_in;
            claim_id_q   <= claim_id_d;
        end
    end

    assign arb_valid_out       = {pending_q[N-1:1] & enable_in[N-1:1], 1'b0};
    assign pending_out         = pending_q;
    assign ext_irq_out         = ext_irq_q;
    assign claim_rsp_valid_out = claim_rsp_q;
    assign claim_id_out        = claim_id_q;

endmodule

// File: tb/tb_plic_gateway_target.sv
// Self-checking bench: directed test-plan scenarios plus random traffic against an event-level model,
// with a 6-stage max-priority arbiter model closing the loop.
module tb_plic_gateway_target;
    localparam int N    = 32;
    localparam int LAT  = 6;
    localparam int ID_W = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         irq_src_in;
    logic [N-1:0]         irq_edge_in;
    logic [N-1:0]         enable_in;
    logic [N-1:0][7:0]    pri_in;
    logic [7:0]           threshold_in;
    logic [N-1:0]         arb_valid_out;
    logic [ID_W-1:0]      arb_id_in;
    logic                 arb_valid_in;
    logic                 ext_irq_out;
    logic                 claim_req_in;
    logic                 claim_rsp_valid_out;
    logic [ID_W-1:0]      claim_id_out;
    logic                 complete_req_in;
    logic [ID_W-1:0]      complete_id_in;
    logic [N-1:0]         pending_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    plic_gateway_target #(.PLIC_NUM_SOURCES(N), .ARB_LATENCY(LAT), .ID_W(ID_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .irq_src_in          (irq_src_in),
        .irq_edge_in         (irq_edge_in),
        .enable_in           (enable_in),
        .pri_in              (pri_in),
        .threshold_in        (threshold_in),
        .arb_valid_out       (arb_valid_out),
        .arb_id_in           (arb_id_in),
        .arb_valid_in        (arb_valid_in),
        .ext_irq_out         (ext_irq_out),
        .claim_req_in        (claim_req_in),
        .claim_rsp_valid_out (claim_rsp_valid_out),
        .claim_id_out        (claim_id_out),
        .complete_req_in     (complete_req_in),
        .complete_id_in      (complete_id_in),
        .pending_out         (pending_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbiter model: highest priority wins, lowest id on ties, LAT cycles of latency.
    function automatic logic [ID_W-1:0] arb_pick(input logic [N-1:0] v);
        int best = 0;
        int best_pri = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i] && int'(pri_in[i]) > best_pri) begin
                best_pri = int'(pri_in[i]);
                best = i;
            end
        end
        return ID_W'(best);
    endfunction

    logic [ID_W-1:0] pipe_id [LAT];
    logic            pipe_v  [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_id[i] <= '0;
                pipe_v[i]  <= 1'b0;
            end
        end else begin
            pipe_id[0] <= arb_pick(arb_valid_out);
            pipe_v[0]  <= |arb_valid_out;
            for (int i = 1; i < LAT; i++) begin
                pipe_id[i] <= pipe_id[i-1];
                pipe_v[i]  <= pipe_v[i-1];
            end
        end
    end
    assign arb_id_in    = pipe_id[LAT-1];
    assign arb_valid_in = pipe_v[LAT-1];

    // Reference model, updated as a set of events per clock.
    bit m_pend [N];
    bit m_svc  [N];
    bit m_held [N];
    bit m_prev [N];
    bit m_mode [N];
    bit m_cvld, m_ext, m_rsp;
    int m_cid, m_blank, m_rid;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_svc[i] = 0; m_held[i] = 0; m_prev[i] = 0; m_mode[i] = 0;
        end
        m_cvld = 0; m_ext = 0; m_rsp = 0; m_cid = 0; m_blank = 0; m_rid = 0;
    endtask

    task automatic model_step();
        bit old_pend [N];
        bit old_svc  [N];
        int claimed;
        int done;
        int aid;
        bit busy;
        bit eligible;
        old_pend = m_pend;
        old_svc  = m_svc;
        claimed  = 0;
        done     = 0;
        if (claim_req_in) begin
            m_rid   = m_cvld ? m_cid : 0;
            claimed = m_rid;
        end
        m_rsp = claim_req_in;
        if (complete_req_in && complete_id_in != 0 && old_svc[complete_id_in])
            done = int'(complete_id_in);
        if (done != 0) begin
            m_svc[done] = 0;
            if (m_held[done]) begin
                m_pend[done] = 1;
                m_held[done] = 0;
            end
        end
        for (int i = 1; i < N; i++) begin
            busy = old_svc[i] || (claimed == i);
            if (irq_edge_in[i]) begin
                if (irq_src_in[i] && !m_prev[i]) begin
                    if (busy) m_held[i] = 1;
                    else      m_pend[i] = 1;
                end
            end else if (irq_src_in[i] && !busy) begin
                m_pend[i] = 1;
            end
            if (irq_edge_in[i] != m_mode[i]) m_held[i] = 0;
            m_mode[i] = irq_edge_in[i];
            m_prev[i] = irq_src_in[i];
        end
        if (claimed != 0) begin
            m_pend[claimed] = 0;
            m_svc[claimed]  = 1;
        end
        aid = int'(arb_id_in);
        eligible = arb_valid_in && aid != 0 && old_pend[aid] && enable_in[aid]
                   && (pri_in[aid] > threshold_in);
        m_cvld = (m_blank == 0 && claimed == 0 && done == 0) ? eligible : 1'b0;
        if (m_blank == 0) m_cid = aid;
        if (claimed != 0 || done != 0) m_blank = LAT;
        else if (m_blank > 0)          m_blank = m_blank - 1;
        m_ext = m_cvld;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_pend;
        logic [N-1:0] exp_av;
        for (int i = 0; i < N; i++) begin
            exp_pend[i] = m_pend[i];
            exp_av[i]   = m_pend[i] & enable_in[i] & (i != 0);
        end
        check("pending_out", 64'(pending_out), 64'(exp_pend));
        check("arb_valid_out", 64'(arb_valid_out), 64'(exp_av));
        check("ext_irq_out", 64'(ext_irq_out), 64'(m_ext));
        check("claim_rsp_valid_out", 64'(claim_rsp_valid_out), 64'(m_rsp));
        check("claim_id_out", 64'(claim_id_out), 64'(m_rid));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic claim_expect(input int exp, input string name);
        claim_req_in = 1'b1;
        tick();
        claim_req_in = 1'b0;
        check({name, "_rsp"}, 64'(claim_rsp_valid_out), 64'(1));
        check(name, 64'(claim_id_out), 64'(exp));
        $display("claim %s: id=%0d", name, claim_id_out);
    endtask

    task automatic complete(input int id);
        complete_req_in = 1'b1;
        complete_id_in  = ID_W'(id);
        tick();
        complete_req_in = 1'b0;
        complete_id_in  = '0;
        $display("complete id=%0d", id);
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!ext_irq_out && n < 40) begin
            tick();
            n++;
        end
        check({name, "_irq"}, 64'(ext_irq_out), 64'(1));
    endtask

    task automatic pulse(input int i);
        irq_src_in[i] = 1'b1;
        tick();
        irq_src_in[i] = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        irq_src_in = '0; irq_edge_in = '0; enable_in = '1; pri_in = '0;
        threshold_in = 8'd1; claim_req_in = 1'b0; complete_req_in = 1'b0; complete_id_in = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_pending", 64'(pending_out), 64'(0));
        check("reset_ext", 64'(ext_irq_out), 64'(0));
        check("reset_claim_id", 64'(claim_id_out), 64'(0));

        // Level source 5
        pri_in[5] = 8'd3;
        irq_src_in[5] = 1'b1;
        wait_irq("lvl5");
        claim_expect(5, "lvl5_claim");
        check("lvl5_pend_cleared", 64'(pending_out[5]), 64'(0));
        check("lvl5_ext_dropped", 64'(ext_irq_out), 64'(0));
        complete(5);
        tick();
        check("lvl5_repend", 64'(pending_out[5]), 64'(1));
        irq_src_in[5] = 1'b0;
        wait_irq("lvl5b");
        claim_expect(5, "lvl5_claim2");
        complete(5);

        // Edge source 7 with held edges
        irq_edge_in[7] = 1'b1;
        pri_in[7] = 8'd2;
        tick();
        pulse(7);
        wait_irq("edge7");
        claim_expect(7, "edge7_claim");
        pulse(7);
        pulse(7);
        complete(7);
        check("edge7_held_once", 64'(pending_out[7]), 64'(1));
        wait_irq("edge7b");
        claim_expect(7, "edge7_claim2");
        complete(7);
        repeat (20) tick();
        check("edge7_no_more", 64'(pending_out), 64'(0));
        check("edge7_ext_idle", 64'(ext_irq_out), 64'(0));

        // Sources 3 and 9, blanking, simultaneous claim/complete
        irq_edge_in[3] = 1'b1; irq_edge_in[9] = 1'b1;
        pri_in[3] = 8'd4; pri_in[9] = 8'd6;
        tick();
        irq_src_in[3] = 1'b1; irq_src_in[9] = 1'b1;
        tick();
        irq_src_in[3] = 1'b0; irq_src_in[9] = 1'b0;
        tick();
        wait_irq("pair");
        claim_expect(9, "pair_claim9");
        claim_expect(0, "pair_b2b");
        repeat (6) tick();
        claim_req_in = 1'b1; complete_req_in = 1'b1; complete_id_in = ID_W'(9);
        tick();
        claim_req_in = 1'b0; complete_req_in = 1'b0; complete_id_in = '0;
        check("pair_claim3", 64'(claim_id_out), 64'(3));
        $display("claim pair_claim3+complete9: id=%0d", claim_id_out);
        pulse(9);
        check("pair_9_released", 64'(pending_out), 64'(32'h0000_0200));
        complete(12);
        complete(0);
        tick();
        check("bogus_complete", 64'(pending_out), 64'(32'h0000_0200));
        complete(3);
        wait_irq("pair9b");
        claim_expect(9, "pair_claim9b");
        complete(9);

        // Threshold gating
        pri_in[11] = 8'd2;
        threshold_in = 8'd2;
        irq_src_in[11] = 1'b1;
        repeat (15) tick();
        check("thr_ext_low", 64'(ext_irq_out), 64'(0));
        claim_expect(0, "thr_claim_none");
        threshold_in = 8'd1;
        wait_irq("thr");
        claim_expect(11, "thr_claim11");
        irq_src_in[11] = 1'b0;
        complete(11);
        repeat (10) tick();

        // Asynchronous reset between claim request and response
        irq_src_in[5] = 1'b1;
        wait_irq("rst5");
        claim_req_in = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        claim_req_in = 1'b0;
        irq_src_in[5] = 1'b0;
        check("rst_no_rsp", 64'(claim_rsp_valid_out), 64'(0));
        check("rst_id", 64'(claim_id_out), 64'(0));
        check("rst_ext", 64'(ext_irq_out), 64'(0));
        check("rst_pend", 64'(pending_out), 64'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_ext", 64'(ext_irq_out), 64'(0));
        check("post_rst_pend", 64'(pending_out), 64'(0));
        check("post_rst_rsp", 64'(claim_rsp_valid_out), 64'(0));

        // Random traffic
        for (int i = 1; i < N; i++) begin
            pri_in[i]      = 8'($urandom_range(0, 7));
            irq_edge_in[i] = ($urandom_range(0, 1) == 1);
        end
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(1, N - 1);
                irq_src_in[idx] = ~irq_src_in[idx];
            end
            if ($urandom_range(0, 99) == 0) begin
                idx = $urandom_range(1, N - 1);
                irq_edge_in[idx] = ~irq_edge_in[idx];
            end
            if ($urandom_range(0, 99) == 0) begin
                idx = $urandom_range(1, N - 1);
                enable_in[idx] = ~enable_in[idx];
            end
            if ($urandom_range(0, 99) == 0) begin
                idx = $urandom_range(0, N - 1);
                pri_in[idx] = 8'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 149) == 0) threshold_in = 8'($urandom_range(0, 3));
            claim_req_in = ($urandom_range(0, 5) == 0);
            complete_req_in = ($urandom_range(0, 4) == 0);
            complete_id_in = ID_W'($urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 1; i < N; i++) if (m_svc[i]) complete_id_in = ID_W'(i);
            end
            tick();
            if (claim_rsp_valid_out) $display("claim rnd: id=%0d", claim_id_out);
        end
        claim_req_in = 1'b0;
        complete_req_in = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
